// File: rtl/cnn_bias_relu_pool_pkg.sv
// Shared defaults and elaboration helpers for the bias/ReLU/pool post-processing stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_bias_relu_pool_pkg;

  // Default geometry and widths of the post-accumulator datapath.
  localparam int CNN_ACI_BW = 21;  // signed accumulator width from the CI adder tree
  localparam int CNN_B_BW   = 8;   // signed per-channel bias
  localparam int CNN_OBW    = 8;   // unsigned activation width
  localparam int CNN_SHIFT  = 4;   // requantisation right shift
  localparam int CNN_FMAP_W = 8;   // conv output width in pixels
  localparam int CNN_FMAP_H = 8;   // conv output height in pixels

  // A pooled dimension must split into whole 2x2 windows, and at least two
  // of them so that the pooled index ports are at least one bit wide.
  function automatic bit fmap_dim_ok(input int dim);
    return (dim >= 4) && ((dim % 2) == 0);
  endfunction

  // Requantisation needs headroom: the shift and the activation must fit
  // inside the widened sum, and the bias must not be wider than the accumulator.
  function automatic bit quant_widths_ok(input int aci_bw, input int b_bw,
                                         input int obw, input int shift);
    return (b_bw <= aci_bw) && (obw < aci_bw + 1) && (shift < aci_bw + 1) && (obw < 31);
  endfunction

endpackage

// File: rtl/cnn_relu_quant.sv
// Adds the channel bias, applies ReLU, floor-shifts and saturates to the activation width.
// Latency: 1 cycle from in_valid to act_valid.
// Backpressure: none; every valid input produces a valid output one cycle later unless clr is high.
module cnn_relu_quant
  import cnn_bias_relu_pool_pkg::*;
#(
  parameter int ACI_BW = CNN_ACI_BW,
  parameter int B_BW   = CNN_B_BW,
  parameter int OBW    = CNN_OBW,
  parameter int SHIFT  = CNN_SHIFT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [ACI_BW-1:0] acc,
  input  logic [B_BW-1:0]   bias,
  output logic              act_valid,
  output logic [OBW-1:0]    act
);

  // One extra bit keeps acc + bias exact even at the accumulator extremes.
  localparam int SW = ACI_BW + 1;
  localparam logic [SW-1:0] ACT_MAX = SW'((2 ** OBW) - 1);

  if (!quant_widths_ok(ACI_BW, B_BW, OBW, SHIFT)) begin : g_bad_widths
    $error("cnn_relu_quant: inconsistent ACI_BW/B_BW/OBW/SHIFT");
  end

  logic signed [SW-1:0] sum;
  logic        [SW-1:0] relu;
  logic        [SW-1:0] q;
  logic        [OBW-1:0] act_next;

  // Widened add, clamp negatives to zero, floor shift, then clip to the activation range.
  always_comb begin
    sum      = $signed({acc[ACI_BW-1], acc}) + $signed({{(SW - B_BW){bias[B_BW-1]}}, bias});
    relu     = sum[SW-1] ? '0 : sum;
    q        = relu >> SHIFT;
    act_next = (q > ACT_MAX) ? {OBW{1'b1}} : q[OBW-1:0];
  end

  // Register the activation; clr drops the pixel presented in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_valid <= 1'b0;
      act       <= '0;
    end else begin
      act_valid <= in_valid & ~clr;
      if (in_valid && !clr) begin
        act <= act_next;
      end
    end
  end

endmodule

// File: rtl/cnn_bias_relu_pool.sv
// Bias/ReLU/requant per pixel followed by 2x2 stride-2 max pooling over a raster-ordered channel.
// Latency: 2 cycles from the bottom-right pixel of a window to o_ot_valid.
// Backpressure: none; input may have gaps, only valid cycles advance state.
module cnn_bias_relu_pool
  import cnn_bias_relu_pool_pkg::*;
#(
  parameter int ACI_BW = CNN_ACI_BW,
  parameter int B_BW   = CNN_B_BW,
  parameter int OBW    = CNN_OBW,
  parameter int SHIFT  = CNN_SHIFT,
  parameter int FMAP_W = CNN_FMAP_W,
  parameter int FMAP_H = CNN_FMAP_H
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_in_valid,
  input  logic [ACI_BW-1:0]             i_ci_acc,
  input  logic [B_BW-1:0]               i_bias,
  input  logic                          i_frame_clr,
  output logic                          o_ot_valid,
  output logic [OBW-1:0]                o_ot_act,
  output logic [$clog2(FMAP_W/2)-1:0]   o_ot_col,
  output logic [$clog2(FMAP_H/2)-1:0]   o_ot_row,
  output logic                          o_frame_done
);

  localparam int CW = $clog2(FMAP_W);
  localparam int RW = $clog2(FMAP_H);
  localparam int PW = FMAP_W / 2;
  localparam logic [CW-1:0] COL_LAST = CW'(FMAP_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FMAP_H - 1);

  if (!fmap_dim_ok(FMAP_W)) begin : g_bad_fmap_w
    $error("cnn_bias_relu_pool: FMAP_W must be even and >= 4");
  end
  if (!fmap_dim_ok(FMAP_H)) begin : g_bad_fmap_h
    $error("cnn_bias_relu_pool: FMAP_H must be even and >= 4");
  end

  // Stage 1: per-pixel activation.
  logic           s1_valid;
  logic [OBW-1:0] s1_act;

  cnn_relu_quant #(
    .ACI_BW (ACI_BW),
    .B_BW   (B_BW),
    .OBW    (OBW),
    .SHIFT  (SHIFT)
  ) u_relu_quant (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (i_frame_clr),
    .in_valid  (i_in_valid),
    .acc       (i_ci_acc),
    .bias      (i_bias),
    .act_valid (s1_valid),
    .act       (s1_act)
  );

  // Stage 2 state: position of the pixel currently in stage 1, the left
  // half of the current horizontal pair, and the pooled top-row pairs.
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [OBW-1:0] hold_reg;
  logic [OBW-1:0] linebuf [PW];

  logic [CW-2:0]  col_half;
  logic           col_odd;
  logic           row_odd;
  logic           s2_adv;
  logic [OBW-1:0] pair_max;
  logic [OBW-1:0] lb_rd;
  logic [OBW-1:0] win_max;

  assign col_half = col[CW-1:1];
  assign col_odd  = col[0];
  assign row_odd  = row[0];
  // A pixel in flight is discarded when a clear arrives at the same edge.
  assign s2_adv   = s1_valid & ~i_frame_clr;

  // Max of the horizontal pair, then fold in the stored top-row pair for the full window.
  always_comb begin
    pair_max = (hold_reg > s1_act) ? hold_reg : s1_act;
    lb_rd    = linebuf[col_half];
    win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;
  end

  // Raster counters; wrapping after the last pixel starts the next frame seamlessly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else if (i_frame_clr) begin
      col <= '0;
      row <= '0;
    end else if (s1_valid) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Even columns hold the left pixel of each horizontal pair on every row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg <= '0;
    end else if (i_frame_clr) begin
      hold_reg <= '0;
    end else if (s1_valid && !col_odd) begin
      hold_reg <= s1_act;
    end
  end

  // Top row of each window stores its pair maximum; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (s2_adv && !row_odd && col_odd) begin
      linebuf[col_half] <= pair_max;
    end
  end

  // Bottom-right pixel of a window emits the pooled result; payload holds between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_ot_valid   <= 1'b0;
      o_ot_act     <= '0;
      o_ot_col     <= '0;
      o_ot_row     <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      if (s2_adv && row_odd && col_odd) begin
        o_ot_valid   <= 1'b1;
        o_ot_act     <= win_max;
        o_ot_col     <= col[CW-1:1];
        o_ot_row     <= row[RW-1:1];
        o_frame_done <= (col == COL_LAST) && (row == ROW_LAST);
      end
    end
  end

endmodule

// File: tb/tb_cnn_bias_relu_pool.sv
// Scoreboard bench: stimulus pushes expected pooled outputs, a negedge monitor pops and compares.
module tb_cnn_bias_relu_pool;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_in_valid;
  logic [20:0] i_ci_acc;
  logic [7:0]  i_bias;
  logic        i_frame_clr;
  logic        o_ot_valid;
  logic [7:0]  o_ot_act;
  logic [1:0]  o_ot_col;
  logic [1:0]  o_ot_row;
  logic        o_frame_done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int act;
    int col;
    int row;
    int done;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  cnn_bias_relu_pool #(
    .ACI_BW (21),
    .B_BW   (8),
    .OBW    (8),
    .SHIFT  (4),
    .FMAP_W (8),
    .FMAP_H (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_in_valid   (i_in_valid),
    .i_ci_acc     (i_ci_acc),
    .i_bias       (i_bias),
    .i_frame_clr  (i_frame_clr),
    .o_ot_valid   (o_ot_valid),
    .o_ot_act     (o_ot_act),
    .o_ot_col     (o_ot_col),
    .o_ot_row     (o_ot_row),
    .o_frame_done (o_frame_done)
  );

  task automatic chk(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected entry, including its cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      if (o_frame_done && !o_ot_valid) chk("done_without_valid", 1, 0);
      if (o_ot_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("act", int'(o_ot_act), mon_e.act);
          chk("col", int'(o_ot_col), mon_e.col);
          chk("row", int'(o_ot_row), mon_e.row);
          chk("frame_done", int'(o_frame_done), mon_e.done);
          chk("latency_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  // mode 0: constant base; mode 1: window values 16/32/48 with 64 rotated through the positions.
  function automatic int pix_acc(input int mode, input int base, input int r, input int c);
    int w;
    int p;
    int rank;
    if (mode == 0) return base;
    w    = (r / 2) * 4 + c / 2;
    p    = (r % 2) * 2 + c % 2;
    rank = (p - (w % 4) + 4) % 4;
    return (rank == 0) ? 64 : 16 * rank;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_in_valid  = 1'b0;
      i_frame_clr = 1'b0;
    end
  endtask

  task automatic send_frame(input int mode, input int base, input int bias, input int npix,
                            input int gaps, input int exp_act);
    for (int p = 0; p < npix; p++) begin
      int r;
      int c;
      r = p / 8;
      c = p % 8;
      if (gaps != 0 && $urandom_range(1, 0) == 1) begin
        @(negedge clk);
        i_in_valid  = 1'b0;
        i_frame_clr = 1'b0;
        i_ci_acc    = 21'($urandom);
      end
      @(negedge clk);
      i_in_valid  = 1'b1;
      i_frame_clr = 1'b0;
      i_ci_acc    = 21'(pix_acc(mode, base, r, c));
      i_bias      = 8'(bias);
      if ((r % 2) == 1 && (c % 2) == 1) begin
        exp_t e;
        e.act  = exp_act;
        e.col  = c / 2;
        e.row  = r / 2;
        e.done = (r == 7 && c == 7) ? 1 : 0;
        e.cyc  = cyc + 2;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain(input string name);
    idle(6);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, int'(o_ot_valid), 0);
    chk({tag, "_act"},   int'(o_ot_act), 0);
    chk({tag, "_col"},   int'(o_ot_col), 0);
    chk({tag, "_row"},   int'(o_ot_row), 0);
    chk({tag, "_done"},  int'(o_frame_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    i_in_valid  = 1'b0;
    i_ci_acc    = '0;
    i_bias      = '0;
    i_frame_clr = 1'b0;
    idle(3);
    chk_zero_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // 160 >> 4 = 10 everywhere, continuous valid.
    send_frame(0, 160, 0, 64, 0, 10);
    drain("const_drain");

    // -100+50 clamps to 0; then back-to-back frame -100+120 = 20 >> 4 = 1.
    send_frame(0, -100, 50, 64, 0, 0);
    send_frame(0, -100, 120, 64, 0, 1);
    drain("relu_bias_drain");

    // Saturation, including the most positive accumulator value.
    send_frame(0, 100000, 127, 64, 0, 255);
    send_frame(0, (1 << 20) - 1, 127, 64, 0, 255);
    drain("sat_drain");

    // Window maximum 64 >> 4 = 4 wherever it sits in the window.
    send_frame(1, 0, 0, 64, 0, 4);
    drain("maxsel_drain");

    // Random input gaps must not change the output sequence.
    send_frame(0, 160, 0, 64, 1, 10);
    drain("gaps_drain");

    // Abort: pixels 0..14 pooled normally, pixel 15 in flight is killed by clr,
    // the pixel coinciding with clr is dropped, then a fresh frame of 320 -> 20.
    send_frame(0, 160, 0, 15, 0, 10);
    @(negedge clk);
    i_in_valid  = 1'b1;
    i_ci_acc    = 21'(160);
    @(negedge clk);
    i_in_valid  = 1'b1;
    i_frame_clr = 1'b1;
    i_ci_acc    = 21'(5000);
    send_frame(0, 320, 0, 64, 0, 20);
    drain("clr_drain");

    // Mid-frame asynchronous reset clears held outputs immediately.
    send_frame(0, 160, 0, 20, 0, 10);
    idle(3);
    chk("pre_rst_queue", exp_q.size(), 0);
    chk("pre_rst_act", int'(o_ot_act), 10);
    chk("pre_rst_col", int'(o_ot_col), 3);
    @(negedge clk);
    i_in_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk_zero_outputs("midrst");
    idle(2);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    send_frame(0, 160, 0, 64, 0, 10);
    drain("post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
